// File: rtl/cbb_pkg.sv
// -----------------------------------------------------------------------------
// cbb_pkg
//   Shared definitions for the CBB pipeline building blocks.
//   skid_state_e: occupancy of the two-entry skid buffer.
//     SKID_EMPTY : no beat held
//     SKID_ONE   : one beat in the main register, presented downstream
//     SKID_FULL  : main register presented, a second beat parked in the skid register
//   Encoding 2'd3 is unused. The buffer recovers from it to SKID_EMPTY.
// -----------------------------------------------------------------------------
package cbb_pkg;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_FULL  = 2'd2
  } skid_state_e;

endpackage : cbb_pkg

// File: rtl/cbb_rege.sv
// -----------------------------------------------------------------------------
// cbb_rege
//   Payload register with load enable. It holds its value whenever en_i is low.
//   Parameters:
//     WIDTH    : payload width in bits
//     INIT_VAL : value loaded by reset
//   Ports:
//     clk   in             rising-edge clock
//     rst_n in             asynchronous active-low reset
//     en_i  in             load enable
//     d_i   in  [WIDTH]    next value
//     q_o   out [WIDTH]    registered value
// -----------------------------------------------------------------------------
module cbb_rege #(
  parameter int                 WIDTH    = 8,
  parameter logic [WIDTH-1:0]   INIT_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // NOTE: payload registers take a defined reset value so that out_dat is
  // known immediately after reset, not only after the first beat arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= INIT_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : cbb_rege

// File: rtl/cbb_skid_buf.sv
// -----------------------------------------------------------------------------
// cbb_skid_buf
//   Two-entry valid/ready skid buffer (pipeline register slice).
//   Both in_rdy and out_vld are registered from the next state. As a result no
//   combinational path runs from out_rdy to in_rdy. The buffer sustains one
//   beat per cycle with one cycle of latency. Ordering is strict FIFO.
//
//   Parameters:
//     WIDTH    : payload width in bits
//     INIT_VAL : reset value of both payload registers (and of out_dat)
//     CNT_W    : stall counter width (used only with CBB_SKID_STALL_CNT_EN)
//   Ports:
//     clk        in             rising-edge clock
//     rst        in             asynchronous active-low reset
//     in_vld     in             upstream beat valid
//     in_dat     in  [WIDTH]    upstream payload
//     in_rdy     out            buffer can accept (registered)
//     out_vld    out            downstream beat valid (registered)
//     out_dat    out [WIDTH]    downstream payload (main register)
//     out_rdy    in             downstream accepts
//     stall_cnt  out [CNT_W]    upstream stall cycles, saturating
//                               (present only with CBB_SKID_STALL_CNT_EN)
//   Build option:
//     CBB_SKID_STALL_CNT_EN - adds the stall_cnt port and its counter.
// -----------------------------------------------------------------------------
module cbb_skid_buf
  import cbb_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0,
  parameter int               CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  output logic             in_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  input  logic             out_rdy
`ifdef CBB_SKID_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt
`endif
);

  skid_state_e      state_q, state_d;
  logic             in_rdy_q, out_vld_q;
  logic             xfer_in, xfer_out;
  logic             main_en, skid_en;
  logic [WIDTH-1:0] main_d, skid_q;

  assign xfer_in  = in_vld & in_rdy_q;
  assign xfer_out = out_vld_q & out_rdy;

  // NOTE: every signal written here gets a default first. A missing branch
  // then falls back to "hold" and cannot infer a latch.
  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    unique case (state_q)
      SKID_EMPTY: begin
        if (xfer_in) begin
          state_d = SKID_ONE;
          main_en = 1'b1;
        end
      end
      SKID_ONE: begin
        if (xfer_in && xfer_out) begin
          main_en = 1'b1;             // pass-through: old beat leaves, new one loads
        end else if (xfer_in) begin
          state_d = SKID_FULL;
          skid_en = 1'b1;             // downstream stalled: park the new beat
        end else if (xfer_out) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (xfer_out) begin
          state_d = SKID_ONE;
          main_en = 1'b1;             // parked beat moves up to the output
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Only FULL refills main from skid. Every other load comes from upstream.
  assign main_d = (state_q == SKID_FULL) ? skid_q : in_dat;

  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples pre-edge values regardless of the order of the statements.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= SKID_EMPTY;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_rdy_q  <= (state_d != SKID_FULL);
      out_vld_q <= (state_d != SKID_EMPTY);
    end
  end

  cbb_rege #(
    .WIDTH    (WIDTH),
    .INIT_VAL (INIT_VAL)
  ) u_main (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (out_dat)
  );

  cbb_rege #(
    .WIDTH    (WIDTH),
    .INIT_VAL (INIT_VAL)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (skid_en),
    .d_i   (in_dat),
    .q_o   (skid_q)
  );

  assign in_rdy  = in_rdy_q;
  assign out_vld = out_vld_q;

`ifdef CBB_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  // Counts cycles where upstream offers a beat that the buffer refuses.
  // The counter saturates at all-ones and clears only on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (in_vld && !in_rdy_q && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  // CNT_W sizes only the stall counter. It is referenced here so that the
  // default build carries no dangling parameter.
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule : cbb_skid_buf

// File: tb/tb_cbb_skid_buf.sv
// -----------------------------------------------------------------------------
// tb_cbb_skid_buf
//   Self-checking bench for cbb_skid_buf (WIDTH=8, INIT_VAL=8'hC3, CNT_W=4).
//   It runs directed sequences with hand-derived expectations, then a
//   randomised backpressure run checked against a FIFO scoreboard.
//   The stall counter checks are compiled in with CBB_SKID_STALL_CNT_EN.
// -----------------------------------------------------------------------------
module tb_cbb_skid_buf;

  localparam int         WIDTH    = 8;
  localparam logic [7:0] INIT_VAL = 8'hC3;
  localparam int         CNT_W    = 4;

  logic             clk;
  logic             rst;
  logic             in_vld;
  logic [WIDTH-1:0] in_dat;
  logic             in_rdy;
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;
  logic             out_rdy;
`ifdef CBB_SKID_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
`endif

  int n_checks;
  int n_errors;

  cbb_skid_buf #(
    .WIDTH    (WIDTH),
    .INIT_VAL (INIT_VAL),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_vld    (in_vld),
    .in_dat    (in_dat),
    .in_rdy    (in_rdy),
    .out_vld   (out_vld),
    .out_dat   (out_dat),
    .out_rdy   (out_rdy)
`ifdef CBB_SKID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock. Observation happens 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] q[$];
    logic       iv, pend, hold;
    logic [7:0] idat, hold_dat;

    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    in_vld   = 1'b0;
    in_dat   = 8'h00;
    out_rdy  = 1'b0;

    // Reset values
    #12;
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_in_rdy",  32'(in_rdy),  32'd1);
    check("rst_out_dat", 32'(out_dat), 32'(INIT_VAL));
`ifdef CBB_SKID_STALL_CNT_EN
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    #10 rst = 1'b1;
    tick();

    // Streaming: out_rdy=1, beats 0x01..0x10 each leave one cycle after acceptance
    out_rdy = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_vld = 1'b1;
      in_dat = 8'(k);
      check("stream_in_rdy", 32'(in_rdy), 32'd1);
      tick();
      check("stream_out_vld", 32'(out_vld), 32'd1);
      check("stream_out_dat", 32'(out_dat), 32'(k));
    end
    in_vld = 1'b0;
    tick();
    check("stream_drained", 32'(out_vld), 32'd0);

    // Stall fill: A1, A2 accepted, A3 held off, then all three drain in order
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 8'hA1;
    tick();
    check("fill1_out_dat", 32'(out_dat), 32'hA1);
    check("fill1_in_rdy",  32'(in_rdy),  32'd1);
    in_dat = 8'hA2;
    tick();
    check("fill2_in_rdy",  32'(in_rdy),  32'd0);
    check("fill2_out_dat", 32'(out_dat), 32'hA1);
    in_dat = 8'hA3;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("fill_hold_in_rdy",  32'(in_rdy),  32'd0);
      check("fill_hold_out_vld", 32'(out_vld), 32'd1);
      check("fill_hold_out_dat", 32'(out_dat), 32'hA1);
    end
    out_rdy = 1'b1;
    tick();
    check("drain1_out_dat", 32'(out_dat), 32'hA2);
    check("drain1_in_rdy",  32'(in_rdy),  32'd1);
    tick();
    check("drain2_out_dat", 32'(out_dat), 32'hA3);
    in_vld = 1'b0;
    tick();
    check("drain3_out_vld", 32'(out_vld), 32'd0);

    // Pass-through in ONE
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 8'h55;
    tick();
    in_vld = 1'b0;
    in_dat = 8'hEE;                       // unqualified data must be ignored
    tick();
    check("pt_hold_out_dat", 32'(out_dat), 32'h55);
    check("pt_hold_out_vld", 32'(out_vld), 32'd1);
    in_vld  = 1'b1;
    in_dat  = 8'h66;
    out_rdy = 1'b1;
    tick();
    check("pt_out_dat", 32'(out_dat), 32'h66);
    check("pt_in_rdy",  32'(in_rdy),  32'd1);
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    tick();
    check("pt_one_out_vld", 32'(out_vld), 32'd1);
    check("pt_one_in_rdy",  32'(in_rdy),  32'd1);
    check("pt_one_out_dat", 32'(out_dat), 32'h66);

    // Asynchronous reset while FULL
    in_vld = 1'b1;
    in_dat = 8'hB1;
    tick();
    check("pre_rst_in_rdy", 32'(in_rdy), 32'd0);
    rst = 1'b0;
    #2;
    check("mid_rst_out_vld", 32'(out_vld), 32'd0);
    check("mid_rst_in_rdy",  32'(in_rdy),  32'd1);
    check("mid_rst_out_dat", 32'(out_dat), 32'(INIT_VAL));
`ifdef CBB_SKID_STALL_CNT_EN
    check("mid_rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
    in_vld = 1'b0;
    rst    = 1'b1;
    tick();
    check("post_rst_out_vld", 32'(out_vld), 32'd0);
    check("post_rst_out_dat", 32'(out_dat), 32'(INIT_VAL));

`ifdef CBB_SKID_STALL_CNT_EN
    // Stall counter: fill, then hold in_vld against FULL for 20 cycles
    out_rdy = 1'b0;
    in_vld  = 1'b1;
    in_dat  = 8'hD1;
    tick();
    in_dat = 8'hD2;
    tick();
    check("stall_cnt_fill", 32'(stall_cnt), 32'd0);
    in_dat = 8'hD3;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 5) check("stall_cnt_5", 32'(stall_cnt), 32'd5);
    end
    check("stall_cnt_sat", 32'(stall_cnt), 32'd15);
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    tick();
    tick();
    check("stall_cnt_drain_vld", 32'(out_vld), 32'd0);
    check("stall_cnt_kept", 32'(stall_cnt), 32'd15);
`endif

    // Random backpressure against a FIFO scoreboard. The buffer is empty here.
    q.delete();
    pend = 1'b0;
    hold = 1'b0;
    hold_dat = 8'h00;
    idat = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      if (!pend) begin
        iv   = 1'($urandom_range(0, 1));
        idat = 8'($urandom);
      end
      in_vld  = iv;
      in_dat  = iv ? idat : 8'($urandom);
      out_rdy = 1'($urandom_range(0, 1));

      check("rnd_out_vld", 32'(out_vld), 32'(q.size() != 0));
      check("rnd_in_rdy",  32'(in_rdy),  32'(q.size() < 2));
      if (q.size() != 0) check("rnd_out_dat", 32'(out_dat), 32'(q[0]));
      if (hold)          check("rnd_stable",  32'(out_dat), 32'(hold_dat));

      hold     = (q.size() != 0) && !out_rdy;
      hold_dat = (q.size() != 0) ? q[0] : 8'h00;
      pend     = iv && (q.size() >= 2);
      if (out_rdy && q.size() != 0) void'(q.pop_front());
      if (iv && !pend)              q.push_back(idat);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_cbb_skid_buf
